// File: rtl/mem_bus_arbiter.sv
// Shares the data-RAM/IO bus between the CPU MEM stage and a DMA engine, with DMA starvation relief.
// Bus ownership is decided combinationally each cycle. DMA read data returns two cycles after dma_gnt.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_err,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_DMA_RD, S_DMA_WR} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  state_t      state_next;
  owner_t      owner;
  logic [3:0]  starve_cnt;
  logic [3:0]  starve_next;
  logic        dma_valid;

  // IO-space DMA accesses are rejected outright and never compete for the bus.
  assign dma_valid = dma_req && !dma_addr[7];
  assign dma_err   = dma_req && dma_addr[7];

  always_comb begin
    owner = OWN_NONE;
    if (dma_valid) begin
      if (!cpu_req || starve_cnt >= LIMIT) owner = OWN_DMA;
      else                                 owner = OWN_CPU;
    end else if (cpu_req) begin
      owner = OWN_CPU;
    end
  end

  // State register: remembers who owned the bus in the previous cycle.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_IDLE;
    case (owner)
      OWN_CPU: state_next = S_CPU;
      OWN_DMA: state_next = dma_we ? S_DMA_WR : S_DMA_RD;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_we    = 1'b0;
    dma_gnt   = 1'b0;
    cpu_stall = 1'b0;
    case (owner)
      OWN_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
      end
      OWN_DMA: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = dma_we;
        dma_gnt   = 1'b1;
        cpu_stall = cpu_req;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = mem_rdata;

  // A forced grant resets the count, so the CPU always gets another full window before the next one.
  always_comb begin
    starve_next = starve_cnt;
    if (!dma_req || dma_err || dma_gnt)
      starve_next = 4'd0;
    else if (dma_valid && starve_cnt < LIMIT)
      starve_next = starve_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) starve_cnt <= 4'd0;
    else       starve_cnt <= starve_next;
  end

  // The RAM answers in the cycle after the address cycle; capture it for the DMA side here.
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_rdata  <= 32'h0;
      dma_rvalid <= 1'b0;
    end else begin
      dma_rvalid <= (state == S_DMA_RD);
      if (state == S_DMA_RD) dma_rdata <= mem_rdata;
    end
  end

  a_one_dma_outcome: assert property (@(posedge clk) disable iff (reset) !(dma_gnt && dma_err));
  a_stall_only_on_dma: assert property (@(posedge clk) disable iff (reset) cpu_stall |-> (dma_gnt && cpu_req));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a one-cycle-latency RAM model on the shared bus.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_err, dma_rvalid;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram [0:63];
  logic [4:0]  flg;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_err(dma_err), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Synchronous RAM: read data appears the cycle after the address cycle.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:2]];
  end

  // {mem_we, cpu_stall, dma_gnt, dma_err, dma_rvalid}
  assign flg = {mem_we, cpu_stall, dma_gnt, dma_err, dma_rvalid};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here, checks follow a settle delay.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'hD000_0000 | (i << 2);
    mem_rdata = 32'h0;
    reset = 1'b1;
    idle_inputs();
    cyc(); cyc(); settle();
    check("reset_flags", 32'(flg), 32'h0);
    check("reset_rdata", dma_rdata, 32'h0);
    check("reset_addr", mem_addr, 32'h0);

    // Both sides idle: bus stays parked at zero for 10 cycles.
    cyc(); reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("idle_flags", 32'(flg), 32'h0);
      check("idle_bus", mem_addr | mem_wdata, 32'h0);
      cyc();
    end

    // DMA write with no CPU contention: granted immediately.
    dma_req = 1; dma_we = 1; dma_addr = 32'h04; dma_wdata = 32'hA5A5A5A5;
    settle();
    check("dmawr_flags", 32'(flg), 32'b10100);
    check("dmawr_addr", mem_addr, 32'h04);
    check("dmawr_wdata", mem_wdata, 32'hA5A5A5A5);
    cyc(); idle_inputs();
    cpu_req = 1; cpu_addr = 32'h04;
    settle();
    check("dmawr_no_rvalid", 32'(dma_rvalid), 32'h0);
    check("cpurd_addr", mem_addr, 32'h04);
    check("cpurd_flags", 32'(flg), 32'h0);
    cyc(); cpu_req = 1; cpu_we = 1; cpu_addr = 32'h08; cpu_wdata = 32'h12345678;
    settle();
    check("cpurd_data", cpu_rdata, 32'hA5A5A5A5);
    check("cpuwr_flags", 32'(flg), 32'b10000);
    check("cpuwr_wdata", mem_wdata, 32'h12345678);
    cyc(); idle_inputs();

    // Starvation relief: CPU holds the bus 4 cycles, DMA forced on the 5th, then the window restarts.
    cyc();
    cpu_req = 1; cpu_addr = 32'h20; dma_req = 1; dma_addr = 32'h10;
    for (int i = 1; i <= 5; i++) begin
      settle();
      check("starve_gnt", 32'(dma_gnt), (i == 5) ? 32'h1 : 32'h0);
      check("starve_stall", 32'(cpu_stall), (i == 5) ? 32'h1 : 32'h0);
      check("starve_addr", mem_addr, (i == 5) ? 32'h10 : 32'h20);
      cyc();
    end
    dma_addr = 32'h14;
    for (int i = 6; i <= 10; i++) begin
      settle();
      check("refill_gnt", 32'(dma_gnt), (i == 10) ? 32'h1 : 32'h0);
      check("rd1_rvalid", 32'(dma_rvalid), (i == 7) ? 32'h1 : 32'h0);
      if (i == 7) begin
        check("rd1_data", dma_rdata, 32'hD0000010);
        check("cpu_rdata_passthru", cpu_rdata, 32'hD0000020);
      end
      cyc();
    end
    idle_inputs();
    settle(); check("rd2_wait", 32'(dma_rvalid), 32'h0);
    check("rd1_hold", dma_rdata, 32'hD0000010);
    cyc(); settle();
    check("rd2_rvalid", 32'(dma_rvalid), 32'h1);
    check("rd2_data", dma_rdata, 32'hD0000014);
    cyc();

    // IO-space DMA write with the bus otherwise idle: rejected, no bus access.
    dma_req = 1; dma_we = 1; dma_addr = 32'h80; dma_wdata = 32'hDEADBEEF;
    settle();
    check("ioerr_flags", 32'(flg), 32'b00010);
    check("ioerr_addr", mem_addr, 32'h0);
    cyc(); idle_inputs();
    settle(); check("ioerr_once", 32'(dma_err), 32'h0);

    // An error in the middle of a contended request clears the starvation count.
    cyc();
    cpu_req = 1; cpu_addr = 32'h20; dma_req = 1; dma_addr = 32'h30;
    settle(); check("pre_err_gnt1", 32'(dma_gnt), 32'h0);
    cyc(); settle(); check("pre_err_gnt2", 32'(dma_gnt), 32'h0);
    cyc(); dma_addr = 32'h80; dma_we = 1;
    settle();
    check("err_contended_flags", 32'(flg), 32'b00010);
    check("err_contended_addr", mem_addr, 32'h20);
    cyc(); dma_addr = 32'h30; dma_we = 0;
    for (int i = 1; i <= 5; i++) begin
      settle();
      check("post_err_gnt", 32'(dma_gnt), (i == 5) ? 32'h1 : 32'h0);
      cyc();
    end
    idle_inputs();
    cyc(); cyc();

    // Back-to-back DMA reads: second grant lands in the first read's return cycle.
    dma_req = 1; dma_addr = 32'h00;
    settle(); check("pipe_gnt1", 32'(dma_gnt), 32'h1);
    cyc(); dma_addr = 32'h0C;
    settle(); check("pipe_gnt2", 32'(flg), 32'b00100);
    cyc(); idle_inputs();
    settle();
    check("pipe_rv1", 32'(dma_rvalid), 32'h1);
    check("pipe_d1", dma_rdata, 32'hD0000000);
    cyc(); settle();
    check("pipe_rv2", 32'(dma_rvalid), 32'h1);
    check("pipe_d2", dma_rdata, 32'hD000000C);
    cyc(); settle();
    check("pipe_rv_end", 32'(dma_rvalid), 32'h0);
    check("pipe_hold", dma_rdata, 32'hD000000C);

    // Reset right after a DMA read grant discards the pending return.
    cyc();
    dma_req = 1; dma_addr = 32'h10;
    settle(); check("rst_rd_gnt", 32'(dma_gnt), 32'h1);
    #2 reset = 1'b1;
    cyc(); idle_inputs();
    settle();
    check("rst_rd_rvalid", 32'(dma_rvalid), 32'h0);
    check("rst_rd_rdata", dma_rdata, 32'h0);
    cyc(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("post_rst_rvalid", 32'(dma_rvalid), 32'h0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
